// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: default widths, queue depth and source identifiers.
package cdb_arbiter_pkg;

    localparam int unsigned DATALEN  = 32;
    localparam int unsigned ROBINDEX = 4;
    localparam int unsigned DEPTH    = 2;
    localparam int unsigned NUM_SRC  = 3;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_LSB = 2'd1,
        SRC_ROB = 2'd2
    } cdb_src_e;

    // Next source in round-robin order (ALU -> LSB -> ROB -> ALU).
    function automatic cdb_src_e src_next(input cdb_src_e s);
        cdb_src_e n;
        case (s)
            SRC_ALU: n = SRC_LSB;
            SRC_LSB: n = SRC_ROB;
            default: n = SRC_ALU;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Source-side handshakes and CDB broadcast signals of the arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4
) ();

    logic              alu_valid;
    logic [DATA_W-1:0] alu_value;
    logic [TAG_W-1:0]  alu_tag;
    logic              alu_ready;

    logic              lsb_valid;
    logic [DATA_W-1:0] lsb_value;
    logic [TAG_W-1:0]  lsb_tag;
    logic              lsb_ready;

    logic              rob_valid;
    logic [DATA_W-1:0] rob_value;
    logic [TAG_W-1:0]  rob_tag;
    logic              rob_ready;

    logic              cdb_valid;
    logic [DATA_W-1:0] cdb_value;
    logic [TAG_W-1:0]  cdb_tag;
    logic [1:0]        cdb_src;
    logic              cdb_pending;

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_value, alu_tag,
        input  lsb_valid, lsb_value, lsb_tag,
        input  rob_valid, rob_value, rob_tag,
        output alu_ready, lsb_ready, rob_ready,
        output cdb_valid, cdb_value, cdb_tag, cdb_src, cdb_pending
    );

    // Producer / consumer side.
    modport master (
        output alu_valid, alu_value, alu_tag,
        output lsb_valid, lsb_value, lsb_tag,
        output rob_valid, rob_value, rob_tag,
        input  alu_ready, lsb_ready, rob_ready,
        input  cdb_valid, cdb_value, cdb_tag, cdb_src, cdb_pending
    );

endinterface

// File: rtl/cdb_fifo.sv
// Two-entry shift queue; the head always sits in slot 0.
module cdb_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned W = 36
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic [1:0]   cnt;

    // Queue state update; callers never pop an empty queue or push a full one.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    if (cnt < 2'(DEPTH)) cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    if (cnt != 2'd0) cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                        cnt   <= 2'd1;
                    end else if (cnt == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = slot0;
    assign count = cnt;

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: three 2-entry source queues, round-robin grant,
// registered single-broadcast output.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATALEN,
    parameter int unsigned TAG_W  = ROBINDEX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          clr,
    cdb_arbiter_if.slave  bus
);

    localparam int unsigned ENTRY_W = DATA_W + TAG_W;

    logic [ENTRY_W-1:0] push_data [NUM_SRC];
    logic [ENTRY_W-1:0] head      [NUM_SRC];
    logic [1:0]         count     [NUM_SRC];
    logic [NUM_SRC-1:0] valid;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] ne;
    logic [NUM_SRC-1:0] grant_oh;
    logic               accept;
    logic               grant_any;
    cdb_src_e           grant_src;
    cdb_src_e           cand1;
    cdb_src_e           cand2;
    cdb_src_e           rr_ptr;
    logic [ENTRY_W-1:0] win;

    logic               cdb_valid_q;
    logic [DATA_W-1:0]  cdb_value_q;
    logic [TAG_W-1:0]   cdb_tag_q;
    cdb_src_e           cdb_src_q;

    assign accept = rdy & ~clr & ~rst;

    assign valid = {bus.rob_valid, bus.lsb_valid, bus.alu_valid};
    assign push_data[0] = {bus.alu_tag, bus.alu_value};
    assign push_data[1] = {bus.lsb_tag, bus.lsb_value};
    assign push_data[2] = {bus.rob_tag, bus.rob_value};

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_q
        assign ne[k]    = (count[k] != 2'd0);
        assign ready[k] = accept & (count[k] < 2'(DEPTH));
        assign push[k]  = valid[k] & ready[k];
        assign pop[k]   = grant_oh[k];

        cdb_fifo #(
            .W (ENTRY_W)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (clr),
            .push      (push[k]),
            .pop       (pop[k]),
            .push_data (push_data[k]),
            .head      (head[k]),
            .count     (count[k])
        );
    end

    assign bus.alu_ready   = ready[0];
    assign bus.lsb_ready   = ready[1];
    assign bus.rob_ready   = ready[2];
    assign bus.cdb_pending = |ne;

    // Round-robin search from rr_ptr over queues that were non-empty before this edge.
    always_comb begin
        grant_any = 1'b0;
        grant_src = rr_ptr;
        grant_oh  = '0;
        cand1     = src_next(rr_ptr);
        cand2     = src_next(cand1);
        if (ne[rr_ptr]) begin
            grant_any = 1'b1;
            grant_src = rr_ptr;
        end else if (ne[cand1]) begin
            grant_any = 1'b1;
            grant_src = cand1;
        end else if (ne[cand2]) begin
            grant_any = 1'b1;
            grant_src = cand2;
        end
        if (accept && grant_any) grant_oh[grant_src] = 1'b1;
        win = head[grant_src];
    end

    // Output registers and round-robin pointer: rst over clr over rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid_q <= 1'b0;
            cdb_value_q <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= SRC_ALU;
            rr_ptr      <= SRC_ALU;
        end else if (clr) begin
            cdb_valid_q <= 1'b0;
            rr_ptr      <= SRC_ALU;
        end else if (rdy) begin
            cdb_valid_q <= grant_any;
            if (grant_any) begin
                cdb_value_q <= win[DATA_W-1:0];
                cdb_tag_q   <= win[ENTRY_W-1:DATA_W];
                cdb_src_q   <= grant_src;
                rr_ptr      <= src_next(grant_src);
            end
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clr;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.DATA_W(32), .TAG_W(4)) bus ();

    cdb_arbiter #(
        .DATA_W (32),
        .TAG_W  (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .clr (clr),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 1'b0; bus.alu_value = '0; bus.alu_tag = '0;
        bus.lsb_valid = 1'b0; bus.lsb_value = '0; bus.lsb_tag = '0;
        bus.rob_valid = 1'b0; bus.rob_value = '0; bus.rob_tag = '0;
    endtask

    task automatic chk_cdb(input string tag, input logic v, input logic [31:0] val,
                           input logic [3:0] t, input logic [1:0] src);
        check({tag, ".valid"}, 64'(bus.cdb_valid), 64'(v));
        check({tag, ".value"}, 64'(bus.cdb_value), 64'(val));
        check({tag, ".tag"},   64'(bus.cdb_tag),   64'(t));
        check({tag, ".src"},   64'(bus.cdb_src),   64'(src));
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_tags [5];
        logic [3:0] alu_t;
        logic       acc_a;
        logic       acc_l;

        exp_tags = '{4'd1, 4'd9, 4'd2, 4'd3, 4'd4};

        rst = 1'b1; rdy = 1'b1; clr = 1'b0;
        idle();
        tick();
        tick();
        chk_cdb("reset", 1'b0, 32'h0, 4'h0, 2'd0);
        check("reset.pending",   64'(bus.cdb_pending), 64'd0);
        check("reset.alu_ready", 64'(bus.alu_ready),   64'd0);
        check("reset.lsb_ready", 64'(bus.lsb_ready),   64'd0);
        check("reset.rob_ready", 64'(bus.rob_ready),   64'd0);
        rst = 1'b0;
        #1;
        check("post_rst.alu_ready", 64'(bus.alu_ready), 64'd1);

        // Single ALU push: visible after the second edge only.
        bus.alu_valid = 1'b1; bus.alu_value = 32'h11; bus.alu_tag = 4'd3;
        tick();
        idle();
        check("single.lat_valid", 64'(bus.cdb_valid),   64'd0);
        check("single.pending",   64'(bus.cdb_pending), 64'd1);
        tick();
        chk_cdb("single.bcast", 1'b1, 32'h11, 4'd3, 2'd0);
        tick();
        check("single.after_valid", 64'(bus.cdb_valid),   64'd0);
        check("single.after_pend",  64'(bus.cdb_pending), 64'd0);
        pulse_clr();

        // All three sources at once, pointer at ALU.
        bus.alu_valid = 1'b1; bus.alu_value = 32'hA1; bus.alu_tag = 4'd1;
        bus.lsb_valid = 1'b1; bus.lsb_value = 32'hB2; bus.lsb_tag = 4'd2;
        bus.rob_valid = 1'b1; bus.rob_value = 32'hC3; bus.rob_tag = 4'd3;
        tick();
        idle();
        check("all3.lat_valid", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("all3.first",  1'b1, 32'hA1, 4'd1, 2'd0);
        tick();
        chk_cdb("all3.second", 1'b1, 32'hB2, 4'd2, 2'd1);
        tick();
        chk_cdb("all3.third",  1'b1, 32'hC3, 4'd3, 2'd2);
        tick();
        check("all3.done_valid", 64'(bus.cdb_valid),   64'd0);
        check("all3.done_pend",  64'(bus.cdb_pending), 64'd0);

        // Streaming ALU against a single LSB entry.
        alu_t = 4'd1;
        bus.alu_valid = 1'b1; bus.alu_value = 32'h100; bus.alu_tag = alu_t;
        bus.lsb_valid = 1'b1; bus.lsb_value = 32'h900; bus.lsb_tag = 4'd9;
        for (int i = 0; i < 6; i++) begin
            acc_a = bus.alu_ready;
            acc_l = bus.lsb_ready;
            tick();
            if (acc_l) bus.lsb_valid = 1'b0;
            if (acc_a) begin
                alu_t = alu_t + 4'd1;
                bus.alu_tag   = alu_t;
                bus.alu_value = 32'h100 + 32'(alu_t);
            end
            #1;
            if (i >= 1) begin
                check($sformatf("stream.valid%0d", i), 64'(bus.cdb_valid), 64'd1);
                check($sformatf("stream.tag%0d", i),   64'(bus.cdb_tag),   64'(exp_tags[i-1]));
            end
            if (i == 2) check("stream.lsb_src", 64'(bus.cdb_src), 64'd1);
        end
        idle();
        pulse_clr();

        // LSB entries held while rdy is low.
        bus.lsb_valid = 1'b1; bus.lsb_value = 32'h55; bus.lsb_tag = 4'd5;
        tick();
        bus.lsb_value = 32'h66; bus.lsb_tag = 4'd6;
        tick();
        chk_cdb("hold.first", 1'b1, 32'h55, 4'd5, 2'd1);
        rdy = 1'b0;
        bus.lsb_value = 32'h77; bus.lsb_tag = 4'd7;
        #1;
        check("hold.lsb_ready", 64'(bus.lsb_ready), 64'd0);
        tick();
        chk_cdb("hold.frozen1", 1'b1, 32'h55, 4'd5, 2'd1);
        tick();
        chk_cdb("hold.frozen2", 1'b1, 32'h55, 4'd5, 2'd1);
        check("hold.pending", 64'(bus.cdb_pending), 64'd1);
        rdy = 1'b1;
        idle();
        tick();
        chk_cdb("hold.second", 1'b1, 32'h66, 4'd6, 2'd1);
        tick();
        check("hold.no_third", 64'(bus.cdb_valid),   64'd0);
        check("hold.empty",    64'(bus.cdb_pending), 64'd0);

        // Fill queues, then flush with offers present.
        bus.alu_valid = 1'b1; bus.alu_value = 32'h1; bus.alu_tag = 4'd1;
        bus.lsb_valid = 1'b1; bus.lsb_value = 32'h2; bus.lsb_tag = 4'd2;
        bus.rob_valid = 1'b1; bus.rob_value = 32'h3; bus.rob_tag = 4'd3;
        tick();
        bus.alu_value = 32'h4; bus.alu_tag = 4'd4;
        bus.lsb_value = 32'h5; bus.lsb_tag = 4'd5;
        bus.rob_value = 32'h6; bus.rob_tag = 4'd6;
        tick();
        idle();
        #1;
        chk_cdb("fill.rob_first", 1'b1, 32'h3, 4'd3, 2'd2);
        check("fill.alu_ready", 64'(bus.alu_ready), 64'd0);
        check("fill.lsb_ready", 64'(bus.lsb_ready), 64'd0);
        check("fill.rob_ready", 64'(bus.rob_ready), 64'd1);
        clr = 1'b1;
        bus.alu_valid = 1'b1; bus.alu_value = 32'h8; bus.alu_tag = 4'd8;
        bus.rob_valid = 1'b1; bus.rob_value = 32'h9; bus.rob_tag = 4'd9;
        #1;
        check("clr.alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        clr = 1'b0;
        idle();
        #1;
        check("clr.valid",     64'(bus.cdb_valid),   64'd0);
        check("clr.pending",   64'(bus.cdb_pending), 64'd0);
        check("clr.alu_ready", 64'(bus.alu_ready),   64'd1);
        check("clr.lsb_ready", 64'(bus.lsb_ready),   64'd1);
        check("clr.rob_ready", 64'(bus.rob_ready),   64'd1);
        tick();
        check("clr.no_stale1", 64'(bus.cdb_valid), 64'd0);
        tick();
        check("clr.no_stale2", 64'(bus.cdb_valid), 64'd0);

        // Reset in mid-stream, then a ROB broadcast.
        bus.alu_valid = 1'b1; bus.alu_value = 32'h22; bus.alu_tag = 4'd4;
        tick();
        bus.alu_value = 32'h33; bus.alu_tag = 4'd5;
        tick();
        idle();
        chk_cdb("mrst.before", 1'b1, 32'h22, 4'd4, 2'd0);
        rst = 1'b1;
        #1;
        check("mrst.alu_ready", 64'(bus.alu_ready), 64'd0);
        tick();
        chk_cdb("mrst.reset", 1'b0, 32'h0, 4'h0, 2'd0);
        check("mrst.pending", 64'(bus.cdb_pending), 64'd0);
        rst = 1'b0;
        tick();
        check("mrst.first_valid", 64'(bus.cdb_valid),   64'd0);
        check("mrst.first_pend",  64'(bus.cdb_pending), 64'd0);
        bus.rob_valid = 1'b1; bus.rob_value = 32'hABCD; bus.rob_tag = 4'd7;
        tick();
        idle();
        check("rob.lat_valid", 64'(bus.cdb_valid), 64'd0);
        tick();
        chk_cdb("rob.bcast", 1'b1, 32'hABCD, 4'd7, 2'd2);
        tick();
        check("rob.after_valid", 64'(bus.cdb_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
